// File: rtl/seg_frame_sequencer.sv
// Frame sequencer feeding a shift-register serialiser: snapshots a BCD value,
// sends one 7-segment byte per digit (most significant first), then strobes the latch.
module seg_frame_sequencer #(
    parameter int NUM_DIGITS   = 4,
    parameter bit INVERT       = 1'b0,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [4*NUM_DIGITS-1:0]   i_bcd,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic                      i_busy,
    output logic                      o_load,
    output logic [7:0]                o_data,
    output logic                      o_latch,
    output logic                      o_busy,
    output logic                      o_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LATCH = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] IDX_TOP    = 3'(NUM_DIGITS - 1);
    localparam logic [3:0] LATCH_INIT = 4'(LATCH_CYCLES);

    state_t                    state_r, state_s;
    logic [2:0]                idx_r, idx_s;
    logic [3:0]                cnt_r, cnt_s;
    logic [4*NUM_DIGITS-1:0]   bcd_r, bcd_s;
    logic [NUM_DIGITS-1:0]     dp_r, dp_s;
    logic [3:0]                sel_digit_s;
    logic                      sel_dp_s;

    // Segment byte {dp,g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [7:0] encode(input logic [3:0] digit, input logic dp);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = 8'h3F;
            4'd1:    seg = 8'h06;
            4'd2:    seg = 8'h5B;
            4'd3:    seg = 8'h4F;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'h6D;
            4'd6:    seg = 8'h7D;
            4'd7:    seg = 8'h07;
            4'd8:    seg = 8'h7F;
            4'd9:    seg = 8'h6F;
            default: seg = 8'h00;
        endcase
        seg = seg | {dp, 7'b0000000};
        return seg ^ {8{INVERT}};
    endfunction

    // Next-state, snapshot capture, digit index and latch counter.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        cnt_s   = cnt_r;
        bcd_s   = bcd_r;
        dp_s    = dp_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    bcd_s   = i_bcd;
                    dp_s    = i_dp;
                    idx_s   = IDX_TOP;
                    state_s = ST_ARM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!i_busy) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_ARM;
                end
            end
            ST_LOAD: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // The serialiser raises busy the cycle after a load, so a low here is real.
                if (!i_busy) begin
                    if (idx_r == 3'd0) begin
                        cnt_s   = LATCH_INIT;
                        state_s = ST_LATCH;
                    end else begin
                        idx_s   = idx_r - 3'd1;
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_LATCH: begin
                if (cnt_r <= 4'd1) begin
                    cnt_s   = 4'd0;
                    state_s = ST_DONE;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                    state_s = ST_LATCH;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Digit mux driven by the upcoming index so the byte is ready with the load strobe.
    always_comb begin
        sel_digit_s = 4'd0;
        sel_dp_s    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel_digit_s = (idx_s == 3'(k)) ? bcd_s[4*k +: 4] : sel_digit_s;
            sel_dp_s    = (idx_s == 3'(k)) ? dp_s[k] : sel_dp_s;
        end
    end

    // State, snapshot and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 3'd0;
            cnt_r   <= 4'd0;
            bcd_r   <= '0;
            dp_r    <= '0;
            o_load  <= 1'b0;
            o_data  <= 8'h00;
            o_latch <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            bcd_r   <= bcd_s;
            dp_r    <= dp_s;
            o_load  <= (state_s == ST_LOAD);
            o_data  <= (state_s == ST_LOAD) ? encode(sel_digit_s, sel_dp_s) : o_data;
            o_latch <= (state_s == ST_LATCH);
            o_busy  <= (state_s == ST_ARM) || (state_s == ST_LOAD) ||
                       (state_s == ST_WAIT) || (state_s == ST_LATCH);
            o_done  <= (state_s == ST_DONE);
        end
    end

endmodule

// File: tb/tb_seg_frame_sequencer.sv
// Bench for seg_frame_sequencer: two configurations, each with a 16-cycle serialiser
// busy model, checked against frame timing and byte values derived from the frame rules.
module tb_seg_frame_sequencer;

    typedef int iq_t[$];

    logic        clk = 1'b0;
    logic        rst, start_a, start_b;
    logic [15:0] bcd_a;
    logic [3:0]  dp_a;
    logic [3:0]  bcd_b;
    logic        dp_b;
    logic        busy_a, busy_b;
    logic        load_a, latch_a, obusy_a, done_a;
    logic        load_b, latch_b, obusy_b, done_b;
    logic [7:0]  data_a, data_b;

    int  cnt_a, cnt_b, cyc, t0;
    bit  force_a;
    int  errors = 0;
    int  checks = 0;
    iq_t lc_a, ld_a, lt_a, dn_a, lc_b, ld_b, lt_b, dn_b;

    always #5 clk = ~clk;

    assign busy_a = (cnt_a != 0) || force_a;
    assign busy_b = (cnt_b != 0);

    seg_frame_sequencer #(.NUM_DIGITS(4), .INVERT(1'b0), .LATCH_CYCLES(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_bcd(bcd_a), .i_dp(dp_a),
        .i_busy(busy_a), .o_load(load_a), .o_data(data_a), .o_latch(latch_a),
        .o_busy(obusy_a), .o_done(done_a)
    );

    seg_frame_sequencer #(.NUM_DIGITS(1), .INVERT(1'b1), .LATCH_CYCLES(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_bcd(bcd_b), .i_dp(dp_b),
        .i_busy(busy_b), .o_load(load_b), .o_data(data_b), .o_latch(latch_b),
        .o_busy(obusy_b), .o_done(done_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_byte(input int d, input bit dp, input bit inv);
        int tab[10];
        int v;
        tab = '{32'h3F, 32'h06, 32'h5B, 32'h4F, 32'h66, 32'h6D, 32'h7D, 32'h07, 32'h7F, 32'h6F};
        v = (d < 10) ? tab[d] : 0;
        v = v | (dp ? 128 : 0);
        return inv ? (v ^ 255) : v;
    endfunction

    // Advance one cycle; serialiser model goes busy for 16 cycles starting the cycle after a load.
    task automatic tick();
        int nxt_a, nxt_b;
        nxt_a = load_a ? 16 : ((cnt_a > 0) ? cnt_a - 1 : 0);
        nxt_b = load_b ? 16 : ((cnt_b > 0) ? cnt_b - 1 : 0);
        @(posedge clk);
        #1;
        cyc++;
        cnt_a = nxt_a;
        cnt_b = nxt_b;
        if (load_a) begin lc_a.push_back(cyc); ld_a.push_back(int'(data_a)); end
        if (latch_a) lt_a.push_back(cyc);
        if (done_a) dn_a.push_back(cyc);
        if (load_b) begin lc_b.push_back(cyc); ld_b.push_back(int'(data_b)); end
        if (latch_b) lt_b.push_back(cyc);
        if (done_b) dn_b.push_back(cyc);
    endtask

    task automatic clear_q();
        lc_a.delete(); ld_a.delete(); lt_a.delete(); dn_a.delete();
        lc_b.delete(); ld_b.delete(); lt_b.delete(); dn_b.delete();
    endtask

    task automatic begin_frame(input bit go_b);
        clear_q();
        start_a = 1'b1;
        start_b = go_b;
        t0 = cyc;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Loads every 18 cycles from the first, most significant digit first; latch after the last drains.
    task automatic check_frame(input string tag, input int nd, input int lc, input bit inv,
                               input int first, input logic [31:0] bcd, input logic [7:0] dp,
                               input iq_t lcq, input iq_t ldq, input iq_t ltq, input iq_t dnq);
        int last, k;
        last = first + 18 * (nd - 1);
        chk({tag, "_nloads"}, lcq.size(), nd);
        for (int j = 0; j < nd && j < lcq.size(); j++) begin
            k = nd - 1 - j;
            chk({tag, "_load_cyc"}, lcq[j], first + 18 * j);
            chk({tag, "_load_byte"}, ldq[j], exp_byte(int'(bcd[4*k +: 4]), dp[k], inv));
        end
        chk({tag, "_nlatch"}, ltq.size(), lc);
        for (int j = 0; j < lc && j < ltq.size(); j++)
            chk({tag, "_latch_cyc"}, ltq[j], last + 18 + j);
        chk({tag, "_ndone"}, dnq.size(), 1);
        if (dnq.size() > 0) chk({tag, "_done_cyc"}, dnq[0], last + 18 + lc);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        bcd_a = 16'h0000; dp_a = 4'h0; bcd_b = 4'h0; dp_b = 1'b0;
        cnt_a = 0; cnt_b = 0; force_a = 1'b0; cyc = 0; t0 = 0;
        repeat (3) tick();
        chk("rst_load", load_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_latch", latch_a, 0);
        chk("rst_busy", obusy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_busy_b", obusy_b, 0);
        rst = 1'b0;
        tick();

        // Basic frame; B: single inverted digit 7.
        bcd_a = 16'h1234; dp_a = 4'b0000; bcd_b = 4'h7; dp_b = 1'b0;
        begin_frame(1'b1);
        chk("busy_in_frame", obusy_a, 1);
        repeat (100) tick();
        check_frame("basic_a", 4, 2, 1'b0, t0 + 2, 32'(bcd_a), 8'(dp_a), lc_a, ld_a, lt_a, dn_a);
        check_frame("one_b", 1, 1, 1'b1, t0 + 2, 32'(bcd_b), 8'(dp_b), lc_b, ld_b, lt_b, dn_b);
        chk("data_hold", data_a, 32'h66);
        chk("idle_busy", obusy_a, 0);

        // Decimal point and blanking; B: inverted 8 with dp gives all-off.
        bcd_a = 16'hF9A0; dp_a = 4'b0100; bcd_b = 4'h8; dp_b = 1'b1;
        begin_frame(1'b1);
        repeat (100) tick();
        check_frame("dp_a", 4, 2, 1'b0, t0 + 2, 32'(bcd_a), 8'(dp_a), lc_a, ld_a, lt_a, dn_a);
        check_frame("inv_dp_b", 1, 1, 1'b1, t0 + 2, 32'(bcd_b), 8'(dp_b), lc_b, ld_b, lt_b, dn_b);
        if (ld_a.size() == 4) chk("dp_byte2", ld_a[1], 32'hEF);
        if (ld_b.size() == 1) chk("inv_byte", ld_b[0], 32'h00);

        // Downstream busy at start, plus a start pulse mid-frame that must be ignored.
        bcd_a = 16'h4096; dp_a = 4'b1001; bcd_b = 4'h8; dp_b = 1'b0;
        begin_frame(1'b1);
        force_a = 1'b1;
        repeat (10) tick();
        force_a = 1'b0;
        chk("no_load_while_busy", lc_a.size(), 0);
        repeat (19) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (80) tick();
        check_frame("busy_a", 4, 2, 1'b0, t0 + 12, 32'(bcd_a), 8'(dp_a), lc_a, ld_a, lt_a, dn_a);
        check_frame("inv_b", 1, 1, 1'b1, t0 + 2, 32'(bcd_b), 8'(dp_b), lc_b, ld_b, lt_b, dn_b);

        // Reset during the wait after the second load aborts with no latch or done.
        bcd_a = 16'h5678; dp_a = 4'b0000;
        begin_frame(1'b0);
        repeat (24) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_load", load_a, 0);
        chk("abort_data", data_a, 0);
        chk("abort_latch", latch_a, 0);
        chk("abort_busy", obusy_a, 0);
        chk("abort_done", done_a, 0);
        repeat (100) tick();
        chk("abort_nloads", lc_a.size(), 2);
        chk("abort_nlatch", lt_a.size(), 0);
        chk("abort_ndone", dn_a.size(), 0);
        bcd_a = 16'h9087; dp_a = 4'b0010;
        begin_frame(1'b0);
        repeat (100) tick();
        check_frame("after_rst_a", 4, 2, 1'b0, t0 + 2, 32'(bcd_a), 8'(dp_a), lc_a, ld_a, lt_a, dn_a);

        // Start held high retriggers from IDLE right after DONE.
        bcd_a = 16'h3141; dp_a = 4'b0000;
        clear_q();
        start_a = 1'b1;
        t0 = cyc;
        repeat (78) tick();
        start_a = 1'b0;
        repeat (90) tick();
        chk("retrig_nloads", lc_a.size(), 8);
        chk("retrig_ndone", dn_a.size(), 2);
        if (lc_a.size() > 4) chk("retrig_load4", lc_a[4], t0 + 79);
        if (dn_a.size() > 1) chk("retrig_done2", dn_a[1], t0 + 153);

        // Randomized frames on both configurations.
        for (int r = 0; r < 4; r++) begin
            bcd_a = 16'($urandom);
            dp_a  = 4'($urandom);
            bcd_b = 4'($urandom);
            dp_b  = 1'($urandom);
            begin_frame(1'b1);
            repeat (100) tick();
            check_frame("rand_a", 4, 2, 1'b0, t0 + 2, 32'(bcd_a), 8'(dp_a), lc_a, ld_a, lt_a, dn_a);
            check_frame("rand_b", 1, 1, 1'b1, t0 + 2, 32'(bcd_b), 8'(dp_b), lc_b, ld_b, lt_b, dn_b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
